// File: rtl/aes_sched_if.sv
// Bundle of the client request/response lanes and the shared AES core port.
// The scheduler uses the slave view; the environment (clients plus core) uses the master view.
interface aes_sched_if #(
  parameter int DW = 128
);
  // Two client request lanes, packed {lane1, lane0}
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [3:0]      req_func;
  logic [2*DW-1:0] req_data;

  // Response lanes share one data/error bus
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  // Single AES core
  logic            core_enable;
  logic [1:0]      core_func;
  logic [DW-1:0]   core_data;
  logic            core_done;
  logic [DW-1:0]   core_result;

  modport slave (
    input  req_valid, req_func, req_data, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, core_enable, core_func, core_data
  );

  modport master (
    output req_valid, req_func, req_data, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, core_enable, core_func, core_data
  );
endinterface

// File: rtl/aes_sched.sv
// Two-client round-robin scheduler in front of one AES core.
// Keeps a private key per client and reloads the core key schedule only when
// the requesting client does not own the loaded key or has replaced its key.
// One request is in flight at a time; a watchdog aborts a silent core.
module aes_sched #(
  parameter int DW      = 128,
  parameter int LAT_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  aes_sched_if.slave bus
);

  localparam int WDW = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADKEY = 3'd1,
    S_WAITKEY = 3'd2,
    S_RUN     = 3'd3,
    S_WAITRUN = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t               state_q,     state_d;
  logic [1:0][DW-1:0]   key_q,       key_d;
  logic [1:0]           key_vld_q,   key_vld_d;
  logic [1:0]           key_dirty_q, key_dirty_d;
  logic                 owner_q,     owner_d;
  logic                 owner_vld_q, owner_vld_d;
  logic                 rr_q,        rr_d;
  logic                 cur_q,       cur_d;
  logic [1:0]           cur_func_q,  cur_func_d;
  logic [DW-1:0]        cur_data_q,  cur_data_d;
  logic [WDW-1:0]       wd_q,        wd_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_data_q,  rsp_data_d;
  logic                 rsp_err_q,   rsp_err_d;
  logic                 core_en_q,   core_en_d;
  logic [1:0]           core_func_q, core_func_d;
  logic [DW-1:0]        core_data_q, core_data_d;

  logic                 grant;
  logic [1:0]           req_ready_s;
  logic                 hs;
  logic [1:0]           func_g;
  logic [DW-1:0]        data_g;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Arbitration: pick the single valid client, or the rr pointer when both ask
  always_comb begin
    grant       = 1'b0;
    req_ready_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant = rr_q;
    end else begin
      grant = bus.req_valid[1];
    end
    if (rst && (state_q == S_IDLE) && (bus.req_valid != 2'b00)) begin
      req_ready_s = onehot2(grant);
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign hs     = |(req_ready_s & bus.req_valid);
  assign func_g = grant ? bus.req_func[3:2] : bus.req_func[1:0];
  assign data_g = grant ? bus.req_data[2*DW-1:DW] : bus.req_data[DW-1:0];

  // Next-state and registered-output computation for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_vld_d   = key_vld_q;
    key_dirty_d = key_dirty_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    rr_d        = rr_q;
    cur_d       = cur_q;
    cur_func_d  = cur_func_q;
    cur_data_d  = cur_data_q;
    wd_d        = wd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    core_en_d   = 1'b0;
    core_func_d = 2'b00;
    core_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          rr_d = ~grant;
          case (func_g)
            2'd1: begin
              // New key; dirty forces a reload even if this client owns the core
              key_d[grant]       = data_g;
              key_vld_d[grant]   = 1'b1;
              key_dirty_d[grant] = 1'b1;
            end
            2'd2, 2'd3: begin
              cur_d      = grant;
              cur_func_d = func_g;
              cur_data_d = data_g;
              if (!key_vld_q[grant]) begin
                state_d     = S_RESP;
                rsp_valid_d = onehot2(grant);
                rsp_err_d   = 1'b1;
                rsp_data_d  = '0;
              end else if (!owner_vld_q || (owner_q != grant) || key_dirty_q[grant]) begin
                state_d     = S_LOADKEY;
                core_en_d   = 1'b1;
                core_func_d = 2'd1;
                core_data_d = key_q[grant];
              end else begin
                state_d     = S_RUN;
                core_en_d   = 1'b1;
                core_func_d = func_g;
                core_data_d = data_g;
              end
            end
            default: begin
              // Reserved function: accepted and dropped
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOADKEY: begin
        state_d = S_WAITKEY;
        wd_d    = '0;
      end

      S_WAITKEY: begin
        if (bus.core_done) begin
          owner_d             = cur_q;
          owner_vld_d         = 1'b1;
          key_dirty_d[cur_q]  = 1'b0;
          state_d             = S_RUN;
          core_en_d           = 1'b1;
          core_func_d         = cur_func_q;
          core_data_d         = cur_data_q;
        end else if (wd_q == WDW'(LAT_MAX - 1)) begin
          state_d     = S_RESP;
          owner_vld_d = 1'b0;
          rsp_valid_d = onehot2(cur_q);
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      S_RUN: begin
        state_d = S_WAITRUN;
        wd_d    = '0;
      end

      S_WAITRUN: begin
        if (bus.core_done) begin
          state_d     = S_RESP;
          rsp_valid_d = onehot2(cur_q);
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus.core_result;
        end else if (wd_q == WDW'(LAT_MAX - 1)) begin
          // Core state unknown after an abort: force the next request to reload
          state_d     = S_RESP;
          owner_vld_d = 1'b0;
          rsp_valid_d = onehot2(cur_q);
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready[cur_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = 2'b00;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops all keys and any in-flight work
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      key_vld_q   <= 2'b00;
      key_dirty_q <= 2'b00;
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      rr_q        <= 1'b0;
      cur_q       <= 1'b0;
      cur_func_q  <= 2'b00;
      cur_data_q  <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      core_en_q   <= 1'b0;
      core_func_q <= 2'b00;
      core_data_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_vld_q   <= key_vld_d;
      key_dirty_q <= key_dirty_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      cur_func_q  <= cur_func_d;
      cur_data_q  <= cur_data_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      core_en_q   <= core_en_d;
      core_func_q <= core_func_d;
      core_data_q <= core_data_d;
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.core_enable = core_en_q;
  assign bus.core_func   = core_func_q;
  assign bus.core_data   = core_data_q;

endmodule

// File: tb/tb_aes_sched.sv
// Directed bench for aes_sched with a small AES core model that knows the
// FIPS-197 vectors and tracks which key schedule it currently holds.
module tb_aes_sched;
  localparam int DW       = 128;
  localparam int LAT_MAX  = 64;
  localparam int CORE_LAT = 3;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_sched_if #(.DW(DW)) bus();

  aes_sched #(.DW(DW), .LAT_MAX(LAT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Known-answer table; anything else yields a distinct non-vector value
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [1:0] f,
                                           input logic [127:0] d);
    if (k == K0 && f == 2'd2 && d == P0) return C0;
    else if (k == K0 && f == 2'd3 && d == C0) return P0;
    else if (k == K1 && f == 2'd2 && d == P1) return C1;
    else if (k == K1 && f == 2'd3 && d == C1) return P1;
    else return d ^ k ^ {126'd0, f};
  endfunction

  // AES core model: fixed latency, remembers the last expanded key
  logic         withhold = 1'b0;
  logic         busy;
  int           cnt;
  logic [1:0]   mf;
  logic [127:0] md;
  logic [127:0] mkey;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy             <= 1'b0;
      cnt              <= 0;
      mf               <= 2'd0;
      md               <= '0;
      mkey             <= '0;
      bus.core_done    <= 1'b0;
      bus.core_result  <= '0;
    end else begin
      bus.core_done <= 1'b0;
      if (bus.core_enable) begin
        busy <= 1'b1;
        cnt  <= CORE_LAT;
        mf   <= bus.core_func;
        md   <= bus.core_data;
      end else if (busy) begin
        if (cnt <= 1) begin
          busy <= 1'b0;
          if (!withhold) begin
            bus.core_done <= 1'b1;
            if (mf == 2'd1) begin
              mkey            <= md;
              bus.core_result <= md;
            end else begin
              bus.core_result <= aes_ref(mkey, mf, md);
            end
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Cycle counter and core/response event monitor
  int           cyc = 0;
  int           kexp_n = 0, run_n = 0, en_cyc = 0, done_cyc = 0, rise_cyc = 0;
  logic [127:0] kexp_data = '0;
  logic [1:0]   run_func = 2'd0;
  logic [1:0]   rv_prev = 2'd0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.core_enable) begin
      en_cyc <= cyc;
      if (bus.core_func == 2'd1) begin
        kexp_n    <= kexp_n + 1;
        kexp_data <= bus.core_data;
      end else begin
        run_n    <= run_n + 1;
        run_func <= bus.core_func;
      end
    end
    if (bus.core_done) done_cyc <= cyc;
    if (bus.rsp_valid != 2'b00 && rv_prev == 2'b00) rise_cyc <= cyc;
    rv_prev <= bus.rsp_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [1:0] f, input logic [127:0] d, output int acc);
    int n;
    n = 0;
    bus.req_func[p*2 +: 2]   = f;
    bus.req_data[p*DW +: DW] = d;
    bus.req_valid[p]         = 1'b1;
    #1;
    while (!bus.req_ready[p] && n < 200) begin
      tick();
      n++;
    end
    check("accept", bus.req_ready[p], 1);
    acc = cyc;
    tick();
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic get_rsp(input int p, output logic [127:0] d, output logic e);
    int n;
    n = 0;
    while (!bus.rsp_valid[p] && n < 500) begin
      tick();
      n++;
    end
    check("rsp_onehot", bus.rsp_valid, (p == 1) ? 2'b10 : 2'b01);
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready[p] = 1'b1;
    tick();
    bus.rsp_ready[p] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int           acc, k0, r0, n;
    logic [127:0] rd;
    logic         er;
    logic [1:0]   exp_g;
    logic [1:0]   seen;

    bus.req_valid = 2'b11;
    bus.req_func  = 4'd0;
    bus.req_data  = '0;
    bus.rsp_ready = 2'b00;
    rst = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_flags", {bus.rsp_valid, bus.rsp_err, bus.core_enable, bus.core_func}, 6'd0);
    check("rst_rsp_data", bus.rsp_data, 128'd0);
    check("rst_core_data", bus.core_data, 128'd0);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    repeat (2) tick();

    // Key load then first cipher: one kexp, then cipher
    k0 = kexp_n; r0 = run_n;
    send(0, 2'd1, K0, acc);
    repeat (3) tick();
    check("keyload_no_rsp", bus.rsp_valid, 2'b00);
    check("keyload_no_core", {32'(kexp_n - k0), 32'(run_n - r0)}, 64'd0);
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    check("t1_kexp_cnt", 32'(kexp_n - k0), 32'd1);
    check("t1_kexp_data", kexp_data, K0);
    check("t1_run_cnt", 32'(run_n - r0), 32'd1);
    check("t1_data", rd, C0);
    check("t1_err", er, 1'b0);
    check("t1_rsp_lat", 32'(rise_cyc), 32'(done_cyc + 1));

    // Same cipher again: key already owned, core starts the next cycle
    k0 = kexp_n;
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    check("t2_no_kexp", 32'(kexp_n - k0), 32'd0);
    check("t2_en_lat", 32'(en_cyc), 32'(acc + 1));
    check("t2_func", run_func, 2'd2);
    check("t2_data", rd, C0);

    // Port 1 without a key: immediate error, core untouched
    k0 = kexp_n; r0 = run_n;
    send(1, 2'd2, P1, acc);
    get_rsp(1, rd, er);
    check("t3_err", er, 1'b1);
    check("t3_data", rd, 128'd0);
    check("t3_no_core", {32'(kexp_n - k0), 32'(run_n - r0)}, 64'd0);
    check("t3_lat", 32'(rise_cyc), 32'(acc + 1));

    // Inverse on port 0 (owner), then owner switches each way
    k0 = kexp_n;
    send(0, 2'd3, C0, acc);
    get_rsp(0, rd, er);
    check("t4_inv_no_kexp", 32'(kexp_n - k0), 32'd0);
    check("t4_inv_func", run_func, 2'd3);
    check("t4_inv_data", rd, P0);
    send(1, 2'd1, K1, acc);
    send(1, 2'd2, P1, acc);
    get_rsp(1, rd, er);
    check("t4_p1_kexp", 32'(kexp_n - k0), 32'd1);
    check("t4_p1_key", kexp_data, K1);
    check("t4_p1_data", rd, C1);
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    check("t4_p0_kexp", 32'(kexp_n - k0), 32'd2);
    check("t4_p0_key", kexp_data, K0);
    check("t4_p0_data", rd, C0);

    // Both clients hold reserved requests: grants alternate from rr=1
    k0 = kexp_n; r0 = run_n;
    bus.req_func  = 4'd0;
    bus.req_valid = 2'b11;
    exp_g = 2'b10;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_grant", bus.req_ready, exp_g);
      exp_g = ~exp_g;
      tick();
    end
    bus.req_valid = 2'b00;
    tick();
    check("t5_no_core", {32'(kexp_n - k0), 32'(run_n - r0)}, 64'd0);
    check("t5_no_rsp", bus.rsp_valid, 2'b00);

    // Core withholds done: watchdog error, then the next request reloads
    withhold = 1'b1;
    k0 = kexp_n;
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    withhold = 1'b0;
    check("t6_err", er, 1'b1);
    check("t6_data", rd, 128'd0);
    check("t6_wd_lat", 32'(rise_cyc - en_cyc), 32'(LAT_MAX + 1));
    check("t6_no_kexp", 32'(kexp_n - k0), 32'd0);
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    check("t6_reload", 32'(kexp_n - k0), 32'd1);
    check("t6_after_data", rd, C0);

    // Response held while rsp_ready stays low
    send(1, 2'd2, P1, acc);
    n = 0;
    while (!bus.rsp_valid[1] && n < 500) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t7_hold_valid", {bus.rsp_valid, bus.rsp_err}, 3'b100);
      check("t7_hold_data", bus.rsp_data, C1);
    end
    get_rsp(1, rd, er);
    check("t7_data", rd, C1);

    // Reset while waiting for the cipher result
    r0 = run_n;
    send(0, 2'd2, P0, acc);
    n = 0;
    while (run_n == r0 && n < 200) begin
      tick();
      n++;
    end
    check("t8_reached_run", 32'(run_n - r0), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t8_rst_flags", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.core_enable, bus.core_func}, 8'd0);
    check("t8_rst_rsp_data", bus.rsp_data, 128'd0);
    check("t8_rst_core_data", bus.core_data, 128'd0);
    tick();
    rst = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    check("t8_no_stale_rsp", seen, 2'b00);
    send(0, 2'd2, P0, acc);
    get_rsp(0, rd, er);
    check("t8_key_lost_err", er, 1'b1);
    check("t8_key_lost_data", rd, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
